// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared constants for the writeback scheduler, decode and register file.
// Grant encoding is also used for the arbiter's last_grant state.
package regfile_wb_scheduler_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

endpackage

// File: rtl/regfile_wb_scheduler_wb_rr_arbiter.sv
// Two-input round-robin arbiter for the register file write port.
// Grants depend only on the valids and the last winner.
module wb_rr_arbiter
    import regfile_wb_scheduler_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic a_valid,
    input  logic b_valid,
    output logic a_grant,
    output logic b_grant
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        a_grant = 1'b0;
        b_grant = 1'b0;
        if (!reset) begin
            a_grant = a_valid && (!b_valid || last_grant_q == GRANT_B);
            b_grant = b_valid && (!a_valid || last_grant_q == GRANT_A);
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (a_grant) begin
            last_grant_d = GRANT_A;
        end else if (b_grant) begin
            last_grant_d = GRANT_B;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_q <= GRANT_B;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the register file write port between ALU and load writeback
// and tracks pending destination registers for decode hazard checks.
module regfile_wb_scheduler
    import regfile_wb_scheduler_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                a_valid,
    input  logic [ADDR_W-1:0]   a_rd,
    input  logic [DATA_W-1:0]   a_data,
    output logic                a_ready,
    input  logic                b_valid,
    input  logic [ADDR_W-1:0]   b_rd,
    input  logic [DATA_W-1:0]   b_data,
    output logic                b_ready,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_rd,
    input  logic [ADDR_W-1:0]   query_rs1,
    input  logic [ADDR_W-1:0]   query_rs2,
    input  logic [ADDR_W-1:0]   query_rd,
    output logic                hazard,
    output logic [ADDR_W-1:0]   rf_addr_rd,
    output logic [DATA_W-1:0]   rf_data_rd,
    output logic                rf_write_en,
    output logic [NUM_REGS-1:0] pending
);

    logic                a_grant;
    logic                b_grant;
    logic                wr_en_q;
    logic                wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [ADDR_W-1:0]   wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q;
    logic [DATA_W-1:0]   wr_data_d;
    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    wb_rr_arbiter u_arb (
        .clock   (clock),
        .reset   (reset),
        .a_valid (a_valid),
        .b_valid (b_valid),
        .a_grant (a_grant),
        .b_grant (b_grant)
    );

    // x0 writes are accepted but never reach the register file
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (a_grant) begin
            wr_en_d   = (a_rd != '0);
            wr_addr_d = a_rd;
            wr_data_d = a_data;
        end else if (b_grant) begin
            wr_en_d   = (b_rd != '0);
            wr_addr_d = b_rd;
            wr_data_d = b_data;
        end
    end

    // set after clear: a newly issued producer keeps the reg pending
    always_comb begin
        pending_d = pending_q;
        if (wr_en_q) begin
            pending_d[wr_addr_q] = 1'b0;
        end
        if (issue_valid && issue_rd != '0) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            pending_q <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            pending_q <= pending_d;
        end
    end

    assign a_ready     = a_grant;
    assign b_ready     = b_grant;
    assign rf_write_en = wr_en_q;
    assign rf_addr_rd  = wr_addr_q;
    assign rf_data_rd  = wr_data_q;
    assign pending     = pending_q;
    assign hazard      = pending_q[query_rs1] | pending_q[query_rs2]
                       | pending_q[query_rd];

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Scoreboard bench for regfile_wb_scheduler: expected writes are queued
// at the grant edge and a negedge monitor checks the write port.
module tb_regfile_wb_scheduler;

    logic        clock;
    logic        reset;
    logic        a_valid;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic        b_ready;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  query_rs1;
    logic [4:0]  query_rs2;
    logic [4:0]  query_rd;
    logic        hazard;
    logic [4:0]  rf_addr_rd;
    logic [31:0] rf_data_rd;
    logic        rf_write_en;
    logic [31:0] pending;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    regfile_wb_scheduler dut (
        .clock       (clock),
        .reset       (reset),
        .a_valid     (a_valid),
        .a_rd        (a_rd),
        .a_data      (a_data),
        .a_ready     (a_ready),
        .b_valid     (b_valid),
        .b_rd        (b_rd),
        .b_data      (b_data),
        .b_ready     (b_ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .query_rs1   (query_rs1),
        .query_rs2   (query_rs2),
        .query_rd    (query_rd),
        .hazard      (hazard),
        .rf_addr_rd  (rf_addr_rd),
        .rf_data_rd  (rf_data_rd),
        .rf_write_en (rf_write_en),
        .pending     (pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every write-port cycle must match the head of the queue.
    always @(negedge clock) begin
        if (exp_q.size() > 0 || rf_write_en === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL wr_unexpected: got addr=%0h data=%0h expected no write",
                         rf_addr_rd, rf_data_rd);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (rf_write_en !== 1'b1 || rf_addr_rd !== e.addr ||
                    rf_data_rd !== e.data) begin
                    n_errors++;
                    $display("FAIL wr_port: got en=%0b addr=%0h data=%0h expected en=1 addr=%0h data=%0h",
                             rf_write_en, rf_addr_rd, rf_data_rd, e.addr, e.data);
                end
            end
        end
    end

    task automatic step(input bit push, input logic [4:0] a,
                        input logic [31:0] d);
        @(posedge clock);
        if (push) exp_q.push_back('{addr: a, data: d});
        #1;
    endtask

    initial begin
        reset = 1'b1;
        a_valid = 0; a_rd = 0; a_data = 0;
        b_valid = 0; b_rd = 0; b_data = 0;
        issue_valid = 0; issue_rd = 0;
        query_rs1 = 0; query_rs2 = 0; query_rd = 0;
        step(0, 0, 0);
        step(0, 0, 0);
        reset = 1'b0;

        @(negedge clock);
        chk("rst_pending", pending, 0);
        chk("rst_wen", rf_write_en, 0);
        chk("rst_addr", rf_addr_rd, 0);
        chk("rst_data", rf_data_rd, 0);
        chk("rst_hazard", hazard, 0);
        step(0, 0, 0);

        // contention: A wins first after reset, then alternate
        a_valid = 1; a_rd = 5'd1; a_data = 32'hA1A1_0001;
        b_valid = 1; b_rd = 5'd2; b_data = 32'hB2B2_0002;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("cont_a_ready", a_ready, (i % 2 == 0));
            chk("cont_b_ready", b_ready, (i % 2 == 1));
            if (i % 2 == 0) step(1, 5'd1, 32'hA1A1_0001);
            else            step(1, 5'd2, 32'hB2B2_0002);
        end
        a_valid = 0; b_valid = 0;

        // A only
        a_valid = 1; a_rd = 5'd5; a_data = 32'hDEAD_BEEF;
        @(negedge clock);
        chk("aonly_a_ready", a_ready, 1);
        chk("aonly_b_ready", b_ready, 0);
        step(1, 5'd5, 32'hDEAD_BEEF);
        a_valid = 0;
        @(negedge clock);
        step(0, 0, 0);

        // scoreboard set / clear on rd=7
        issue_valid = 1; issue_rd = 5'd7;
        @(negedge clock);
        chk("sb_pre_issue_hz", hazard, 0);
        step(0, 0, 0);
        issue_valid = 0; query_rs1 = 5'd7;
        @(negedge clock);
        chk("sb_hz_rs1", hazard, 1);
        chk("sb_pending7", pending, 32'h0000_0080);
        step(0, 0, 0);
        query_rs1 = 0; query_rs2 = 5'd7;
        b_valid = 1; b_rd = 5'd7; b_data = 32'h0000_0777;
        @(negedge clock);
        chk("sb_b_ready", b_ready, 1);
        chk("sb_hz_grant", hazard, 1);
        step(1, 5'd7, 32'h0000_0777);
        b_valid = 0;
        @(negedge clock);
        chk("sb_hz_wcycle", hazard, 1);
        step(0, 0, 0);
        @(negedge clock);
        chk("sb_hz_cleared", hazard, 0);
        chk("sb_pending_clr", pending, 0);
        step(0, 0, 0);
        query_rs2 = 0;

        // set/clear collision on rd=3
        issue_valid = 1; issue_rd = 5'd3;
        @(negedge clock);
        step(0, 0, 0);
        issue_valid = 0;
        a_valid = 1; a_rd = 5'd3; a_data = 32'h3333_0003;
        @(negedge clock);
        chk("col_a_ready", a_ready, 1);
        step(1, 5'd3, 32'h3333_0003);
        a_valid = 0;
        issue_valid = 1; issue_rd = 5'd3;
        @(negedge clock);
        step(0, 0, 0);
        issue_valid = 0; query_rd = 5'd3;
        @(negedge clock);
        chk("col_pending3", pending, 32'h0000_0008);
        chk("col_hz_rd", hazard, 1);
        step(0, 0, 0);
        b_valid = 1; b_rd = 5'd3; b_data = 32'h3333_0033;
        @(negedge clock);
        step(1, 5'd3, 32'h3333_0033);
        b_valid = 0;
        @(negedge clock);
        step(0, 0, 0);
        @(negedge clock);
        chk("col_clear", pending, 0);
        step(0, 0, 0);
        query_rd = 0;

        // x0 writeback and issue
        a_valid = 1; a_rd = 5'd0; a_data = 32'h5555_5555;
        @(negedge clock);
        chk("x0_a_ready", a_ready, 1);
        step(0, 0, 0);
        a_valid = 0;
        issue_valid = 1; issue_rd = 5'd0;
        @(negedge clock);
        step(0, 0, 0);
        issue_valid = 0;
        @(negedge clock);
        chk("x0_pending", pending, 0);
        chk("x0_hz_rs1", hazard, 0);
        step(0, 0, 0);

        // reset in the grant cycle; make last_grant=A beforehand
        a_valid = 1; a_rd = 5'd4; a_data = 32'h4444_0004;
        @(negedge clock);
        step(1, 5'd4, 32'h4444_0004);
        a_valid = 0;
        issue_valid = 1; issue_rd = 5'd9;
        @(negedge clock);
        step(0, 0, 0);
        issue_valid = 0;
        a_valid = 1; a_rd = 5'd10; a_data = 32'h1010_0010;
        reset = 1'b1;
        @(negedge clock);
        step(0, 0, 0);
        reset = 1'b0; a_valid = 0;
        @(negedge clock);
        chk("rmid_wen", rf_write_en, 0);
        chk("rmid_pending", pending, 0);
        chk("rmid_addr", rf_addr_rd, 0);
        step(0, 0, 0);
        a_valid = 1; a_rd = 5'd11; a_data = 32'h1111_0011;
        b_valid = 1; b_rd = 5'd12; b_data = 32'h1212_0012;
        @(negedge clock);
        chk("rmid_first_a", a_ready, 1);
        chk("rmid_first_b", b_ready, 0);
        step(1, 5'd11, 32'h1111_0011);
        @(negedge clock);
        chk("rmid_second_b", b_ready, 1);
        step(1, 5'd12, 32'h1212_0012);
        a_valid = 0; b_valid = 0;
        @(negedge clock);
        step(0, 0, 0);
        @(negedge clock);
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
